// File: rtl/alu_ops_pkg.sv
// Op-code and state definitions for the execute stage, shared with the ALU-control decoder.
package alu_ops_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_SLL     = 6'b000000;
  localparam logic [5:0] OP_BCOND   = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_JR      = 6'b001000;
  localparam logic [5:0] OP_DEFAULT = 6'b010101;
  localparam logic [5:0] OP_MUL     = 6'b011000;
  localparam logic [5:0] OP_ADD     = 6'b100000;
  localparam logic [5:0] OP_SUB     = 6'b100010;
  localparam logic [5:0] OP_AND     = 6'b100100;
  localparam logic [5:0] OP_OR      = 6'b100101;
  localparam logic [5:0] OP_XOR     = 6'b100110;
  localparam logic [5:0] OP_NOR     = 6'b100111;
  localparam logic [5:0] OP_SLT     = 6'b101010;
  localparam logic [5:0] OP_SRL     = 6'b111111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Low product bits are identical for signed and unsigned operands, so unsigned math is used.
module seq_multiplier
  import alu_ops_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              last,
  output logic [DATA_W-1:0] product
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W-1:0] acc_p0;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] digit;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_next;

  assign digit    = DATA_W'(a_p0[BITS_PER_CYCLE-1:0]);
  assign partial  = b_p0 * digit;
  assign acc_next = acc_p0 + partial;
  assign last     = busy && (cnt == CNT_W'(N - 1));
  // The final partial product is folded in combinationally so the caller can register it on the last edge.
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

  // Iteration stage: operand shift registers and accumulator
  always_ff @(posedge clk) begin
    if (start) begin
      a_p0   <= a;
      b_p0   <= b;
      acc_p0 <= '0;
    end else if (busy) begin
      a_p0   <= a_p0 >> BITS_PER_CYCLE;
      b_p0   <= b_p0 << BITS_PER_CYCLE;
      acc_p0 <= acc_next;
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: single-cycle ALU and branch compare, plus an iterative MUL that stalls upstream.
module ex_alu_stage
  import alu_ops_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  input  logic [5:0]        ALUControl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [4:0]        Shamt,
  input  logic              RtSel,
  input  logic [4:0]        DestIn,
  input  logic              Flush,
  output logic [DATA_W-1:0] Result,
  output logic              BranchTaken,
  output logic [4:0]        DestOut,
  output logic              OutValid,
  output logic              Stall
);

  state_t                   state;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [DATA_W-1:0]        alu_res;
  logic                     br_taken;
  logic                     is_mul;
  logic                     mul_start;
  logic                     mul_busy;
  logic                     mul_last;
  logic [DATA_W-1:0]        mul_product;
  logic [4:0]               dest_p0;

  assign a_s       = A;
  assign b_s       = B;
  assign is_mul    = (ALUControl == OP_MUL);
  assign mul_start = (state == IDLE) && InValid && is_mul && !Flush;

  // Flush and Reset both kill the op, so upstream must not be held in their cycle.
  assign Stall = !Reset && !Flush &&
                 (((state == IDLE) && InValid && is_mul) || (mul_busy && !mul_last));

  always_comb begin
    alu_res  = '0;
    br_taken = 1'b0;
    case (ALUControl)
      OP_ADD:   alu_res = A + B;
      OP_SUB:   alu_res = A - B;
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_NOR:   alu_res = ~(A | B);
      OP_XOR:   alu_res = A ^ B;
      OP_SLL:   alu_res = B << Shamt;
      OP_SRL:   alu_res = B >> Shamt;
      OP_SLT:   alu_res = {{(DATA_W - 1){1'b0}}, (a_s < b_s)};
      OP_JR:    alu_res = A;
      OP_BCOND: br_taken = RtSel ? (a_s >= 0) : (a_s < 0);
      OP_BEQ:   br_taken = (A == B);
      OP_BNE:   br_taken = (A != B);
      OP_BGTZ:  br_taken = (a_s > 0);
      OP_BLEZ:  br_taken = (a_s <= 0);
      OP_J, OP_JAL, OP_DEFAULT: alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  seq_multiplier #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mul (
    .clk    (Clk),
    .rst    (Reset),
    .start  (mul_start),
    .flush  (Flush),
    .a      (A),
    .b      (B),
    .busy   (mul_busy),
    .last   (mul_last),
    .product(mul_product)
  );

  always_ff @(posedge Clk) begin
    if (mul_start) dest_p0 <= DestIn;
  end

  // Output stage: EX/MEM register and state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      Result      <= '0;
      BranchTaken <= 1'b0;
      DestOut     <= '0;
      OutValid    <= 1'b0;
    end else if (Flush) begin
      state    <= IDLE;
      OutValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid && is_mul) begin
            state    <= BUSY;
            OutValid <= 1'b0;
          end else if (InValid) begin
            Result      <= alu_res;
            BranchTaken <= br_taken;
            DestOut     <= DestIn;
            OutValid    <= 1'b1;
          end else begin
            OutValid <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_last) begin
            state       <= IDLE;
            Result      <= mul_product;
            BranchTaken <= 1'b0;
            DestOut     <= dest_p0;
            OutValid    <= 1'b1;
          end else begin
            OutValid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, branches, MUL timing at two widths, flush and reset.
module tb_ex_alu_stage;
  import alu_ops_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, InValid, valid4, RtSel, Flush;
  logic [5:0]  ALUControl;
  logic [31:0] A, B;
  logic [4:0]  Shamt, DestIn;
  logic [31:0] Result, Result4;
  logic        BranchTaken, BranchTaken4, OutValid, OutValid4, Stall, Stall4;
  logic [4:0]  DestOut, DestOut4;

  int checks = 0;
  int errors = 0;
  int ncyc, nstall, nvalid;

  always #5 Clk = ~Clk;

  ex_alu_stage dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .ALUControl(ALUControl), .A(A), .B(B),
    .Shamt(Shamt), .RtSel(RtSel), .DestIn(DestIn), .Flush(Flush), .Result(Result),
    .BranchTaken(BranchTaken), .DestOut(DestOut), .OutValid(OutValid), .Stall(Stall)
  );

  ex_alu_stage #(.BITS_PER_CYCLE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .InValid(valid4), .ALUControl(ALUControl), .A(A), .B(B),
    .Shamt(Shamt), .RtSel(RtSel), .DestIn(DestIn), .Flush(Flush), .Result(Result4),
    .BranchTaken(BranchTaken4), .DestOut(DestOut4), .OutValid(OutValid4), .Stall(Stall4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  task automatic op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] sh, input logic rt, input logic [4:0] d);
    ALUControl = code; A = a; B = b; Shamt = sh; RtSel = rt; DestIn = d; InValid = 1'b1;
    edge1();
  endtask

  task automatic run_mul(input bit use4, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int cyc_n, output int stalls);
    ALUControl = OP_MUL; A = a; B = b; DestIn = d;
    if (use4) valid4 = 1'b1; else InValid = 1'b1;
    cyc_n = 0;
    stalls = 0;
    do begin
      #1;
      if (use4 ? Stall4 : Stall) stalls++;
      edge1();
      cyc_n++;
      if (cyc_n == 1) begin
        InValid = 1'b0;
        valid4  = 1'b0;
      end
    end while (!(use4 ? OutValid4 : OutValid) && cyc_n < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; valid4 = 1'b0; Flush = 1'b0; RtSel = 1'b0;
    ALUControl = OP_ADD; A = '0; B = '0; Shamt = '0; DestIn = '0;
    edge1();
    edge1();
    chk("rst_result", Result, 32'h0);
    chk("rst_outvalid", 32'(OutValid), 32'h0);
    chk("rst_branch", 32'(BranchTaken), 32'h0);
    chk("rst_dest", 32'(DestOut), 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    Reset = 1'b0;

    op(OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 5'd5);
    chk("add_wrap_result", Result, 32'h0);
    chk("add_outvalid", 32'(OutValid), 32'h1);
    chk("add_dest", 32'(DestOut), 32'd5);
    op(OP_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 5'd6);
    chk("slt_signed", Result, 32'h1);
    op(OP_SUB, 32'h5, 32'h7, 5'd0, 1'b0, 5'd6);
    chk("sub_wrap", Result, 32'hFFFFFFFE);
    op(OP_NOR, 32'h0F0F0000, 32'h000000F0, 5'd0, 1'b0, 5'd6);
    chk("nor", Result, 32'hF0F0FF0F);
    op(OP_SLL, 32'h0, 32'h00000003, 5'd4, 1'b0, 5'd6);
    chk("sll", Result, 32'h00000030);
    op(OP_SRL, 32'h0, 32'h80000000, 5'd31, 1'b0, 5'd6);
    chk("srl_logical", Result, 32'h1);
    op(OP_DEFAULT, 32'h5, 32'h5, 5'd0, 1'b0, 5'd7);
    chk("default_result", Result, 32'h0);
    chk("default_branch", 32'(BranchTaken), 32'h0);
    chk("default_outvalid", 32'(OutValid), 32'h1);

    op(OP_BCOND, 32'h0, 32'h0, 5'd0, 1'b1, 5'd0);
    chk("bgez_zero", 32'(BranchTaken), 32'h1);
    chk("branch_result_zero", Result, 32'h0);
    op(OP_BCOND, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0);
    chk("bltz_zero", 32'(BranchTaken), 32'h0);
    op(OP_BCOND, 32'h80000000, 32'h0, 5'd0, 1'b0, 5'd0);
    chk("bltz_neg", 32'(BranchTaken), 32'h1);
    op(OP_BNE, 32'h3, 32'h3, 5'd0, 1'b0, 5'd0);
    chk("bne_equal", 32'(BranchTaken), 32'h0);
    op(OP_BEQ, 32'h3, 32'h3, 5'd0, 1'b0, 5'd0);
    chk("beq_equal", 32'(BranchTaken), 32'h1);
    op(OP_BLEZ, 32'h80000000, 32'h0, 5'd0, 1'b0, 5'd0);
    chk("blez_minint", 32'(BranchTaken), 32'h1);
    op(OP_BGTZ, 32'h80000000, 32'h0, 5'd0, 1'b0, 5'd0);
    chk("bgtz_minint", 32'(BranchTaken), 32'h0);
    op(OP_JR, 32'h00400010, 32'h0, 5'd0, 1'b0, 5'd0);
    chk("jr_result", Result, 32'h00400010);
    chk("jr_branch", 32'(BranchTaken), 32'h0);

    op(OP_ADD, 32'd10, 32'd20, 5'd0, 1'b0, 5'd7);
    InValid = 1'b0;
    edge1();
    chk("idle_outvalid", 32'(OutValid), 32'h0);
    chk("idle_hold_result", Result, 32'd30);

    run_mul(1'b0, 32'hFFFFFFFE, 32'd7, 5'd9, ncyc, nstall);
    chk("mul1_latency", 32'(ncyc), 32'd33);
    chk("mul1_stalls", 32'(nstall), 32'd32);
    chk("mul1_result", Result, 32'hFFFFFFF2);
    chk("mul1_dest", 32'(DestOut), 32'd9);
    chk("mul1_branch", 32'(BranchTaken), 32'h0);

    run_mul(1'b1, 32'hFFFFFFFE, 32'd7, 5'd10, ncyc, nstall);
    chk("mul4_latency", 32'(ncyc), 32'd9);
    chk("mul4_stalls", 32'(nstall), 32'd8);
    chk("mul4_result", Result4, 32'hFFFFFFF2);
    chk("mul4_dest", 32'(DestOut4), 32'd10);

    ALUControl = OP_MUL; A = 32'd3; B = 32'd5; DestIn = 5'd11; InValid = 1'b1;
    edge1();
    InValid = 1'b0;
    for (int i = 0; i < 10; i++) edge1();
    Flush = 1'b1;
    op(OP_ADD, 32'd100, 32'd1, 5'd0, 1'b0, 5'd20);
    chk("flush_outvalid", 32'(OutValid), 32'h0);
    chk("flush_no_accept", Result, 32'hFFFFFFF2);
    Flush = 1'b0;
    op(OP_ADD, 32'd2, 32'd3, 5'd0, 1'b0, 5'd12);
    chk("post_flush_add", Result, 32'd5);
    chk("post_flush_valid", 32'(OutValid), 32'h1);
    chk("post_flush_dest", 32'(DestOut), 32'd12);
    InValid = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      edge1();
      if (OutValid) nvalid++;
    end
    chk("flush_discard", 32'(nvalid), 32'h0);

    ALUControl = OP_MUL; A = 32'd3; B = 32'd4; DestIn = 5'd13; InValid = 1'b1;
    edge1();
    InValid = 1'b0;
    for (int i = 0; i < 5; i++) edge1();
    Reset = 1'b1;
    #1;
    chk("rst_busy_stall_now", 32'(Stall), 32'h0);
    edge1();
    edge1();
    chk("rstb_result", Result, 32'h0);
    chk("rstb_outvalid", 32'(OutValid), 32'h0);
    chk("rstb_dest", 32'(DestOut), 32'h0);
    Reset = 1'b0;
    #1;
    chk("rstb_stall_after", 32'(Stall), 32'h0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      edge1();
      if (OutValid) nvalid++;
    end
    chk("rstb_discard", 32'(nvalid), 32'h0);
    op(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b0, 5'd3);
    chk("rstb_add", Result, 32'd2);
    InValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage datapath directly downstream of the ALU-control decoder. Consumes the 6-bit ALUControl code, the operands and the shift amount. Produces a registered result, a branch-condition flag and a destination tag for the EX/MEM boundary.
- Single-cycle ops complete in 1 cycle.
- MUL runs on an iterative shift-add multiplier; Stall freezes upstream stages while it is busy.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4. Iteration count N = 32/BITS_PER_CYCLE.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- InValid  input  1  operands/code valid this cycle
- ALUControl  input  6  operation code from ALU-control decoder
- A  input  32  operand rs
- B  input  32  operand rt / sign-extended immediate
- Shamt  input  5  shift amount
- RtSel  input  1  for code 000001: 0=BLTZ, 1=BGEZ
- DestIn  input  5  destination register tag
- Flush  input  1  kill in-flight op (branch mispredict)
- Result  output  32  registered result
- BranchTaken  output  1  registered branch condition
- DestOut  output  5  registered DestIn of completed op
- OutValid  output  1  Result/BranchTaken/DestOut valid
- Stall  output  1  combinational; upstream must hold its outputs while high

Behaviour:
- Reset: Result=0, BranchTaken=0, DestOut=0, OutValid=0, state IDLE, Stall=0. Reset has priority over Flush and over every other input, including in BUSY.
- Op codes:
  - 100000 add A+B; 100010 sub A-B; both wrap mod 2^32, no overflow trap.
  - 100100 and; 100101 or; 100111 nor; 100110 xor.
  - 000000 sll B<<Shamt; 111111 srl B>>Shamt (logical).
  - 101010 slt: signed A<B gives 1, else 0.
  - 001000 jr: Result=A.
  - 011000 mul: low 32 bits of A*B (identical for signed and unsigned).
- Branch codes (Result=0):
  - 000001: BranchTaken = RtSel ? (A>=0) : (A<0), signed.
  - 000100 beq: A==B. 000101 bne: A!=B.
  - 000111 bgtz: A>0 signed. 000110 blez: A<=0 signed.
- 000010 j, 000011 jal, 010101 default and any unlisted code: Result=0, BranchTaken=0, OutValid still asserted.
- BranchTaken=0 for all non-branch codes.
- State IDLE:
  - InValid=1 with a non-MUL code: Result, BranchTaken and DestOut are registered at the next edge, with OutValid=1.
  - InValid=1 with MUL: latch A, B and DestIn; clear the accumulator and iteration counter; go to BUSY. Stall=1 this cycle. OutValid=0 at the next edge.
  - InValid=0: OutValid=0 at the next edge. Result, BranchTaken and DestOut hold their previous values.
- State BUSY:
  - Each cycle adds B' * (BITS_PER_CYCLE low bits of A') to the accumulator, then shifts A' right and B' left by BITS_PER_CYCLE. The counter increments.
  - Stall=1 except on the last iteration (counter==N-1), when Stall=0 so upstream advances at that edge.
  - At that edge: Result=accumulator, DestOut=latched tag, BranchTaken=0, OutValid=1, next state IDLE.
  - Inputs are ignored throughout BUSY. OutValid=0 on every BUSY edge except the final one.
- MUL timing: total latency N+1 cycles from acceptance; N stall cycles; N=32 at the default.
- Flush=1 in any state: next state IDLE, OutValid=0 at the next edge, multiplier result discarded. Stall is forced 0 combinationally in that cycle and the same-cycle input is not accepted.
- Back-to-back MULs: the second MUL is accepted in the IDLE cycle immediately after the first completes; there are no bubbles beyond its own stalls.

Decomposition:
- Package alu_ops_pkg: the 6-bit localparams for every op code above (OP_ADD, OP_MUL, OP_SRL=6'b111111, OP_DEFAULT=6'b010101, ...) and the state encoding (IDLE, BUSY). Shared with the ALU-control decoder.
- One sub-module, seq_multiplier:
  - Inputs: start, a, b, flush.
  - Outputs: busy, last, product.
  - Parameterised by BITS_PER_CYCLE.
  - Owns the accumulator and the counter.
- The top level holds the combinational ALU/compare logic, the output register and Stall generation.

Test Plan:
- Reset held 2 cycles during a MUL in BUSY → all outputs 0, state IDLE, Stall=0 on the next cycle.
- add A=0xFFFFFFFF, B=1, DestIn=5 → one cycle later Result=0, OutValid=1, DestOut=5. slt A=0xFFFFFFFF, B=1 → Result=1.
- mul A=0xFFFFFFFE (-2), B=7, default parameter:
  - Stall high for 32 cycles (acceptance cycle plus 31 BUSY), low on the 32nd BUSY cycle.
  - Result=0xFFFFFFF2 after 33 cycles.
  - Repeat with BITS_PER_CYCLE=4 → 8 stall cycles.
- Branch sweep: bgez (RtSel=1) with A=0 → BranchTaken=1. bltz with A=0 → 0. bne A=B=3 → 0. blez A=0x80000000 → 1.
- Flush asserted at BUSY iteration 10 → OutValid stays 0, Stall=0 that cycle, and a following add completes normally one cycle later.
- srl code 111111 with B=0x80000000, Shamt=31 → Result=1. Code 010101 → Result=0, BranchTaken=0, OutValid=1.
